mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 60 ++++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_load_align.sv | 39 +++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM states, width codes, fault codes
// and the request-side legality / lane helpers.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Unsigned widths only exist for loads; both op bits set is treated as illegal.
  function automatic logic op_legal(input logic       is_load,
                                    input logic       is_store,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic width_ok;
    logic aligned;
    width_ok = 1'b0;
    aligned  = 1'b0;
    case (funct3)
      F3_BYTE:   begin width_ok = 1'b1;    aligned = 1'b1;          end
      F3_HALF:   begin width_ok = 1'b1;    aligned = ~addr_lo[0];   end
      F3_WORD:   begin width_ok = 1'b1;    aligned = (addr_lo == 2'b00); end
      F3_BYTE_U: begin width_ok = is_load; aligned = 1'b1;          end
      F3_HALF_U: begin width_ok = is_load; aligned = ~addr_lo[0];   end
      default:   begin width_ok = 1'b0;    aligned = 1'b0;          end
    endcase
    return width_ok && aligned && !(is_load && is_store);
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Memory-side request/response bus between the memory stage and the data memory.
interface mem_stage_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load lane select: picks the byte/half addressed by addr_lo out
// of the returned word and sign- or zero-extends it according to funct3.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lanes [4];
  logic [15:0] half_lanes [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lanes[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lanes[gi] = rdata[16*gi +: 16];
  end

  assign byte_sel = byte_lanes[addr_lo];
  assign half_sel = half_lanes[addr_lo[1]];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_BYTE:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_BYTE_U: data = {24'h0, byte_sel};
      F3_HALF:   data = {{16{half_sel[15]}}, half_sel};
      F3_HALF_U: data = {16'h0, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: checks the access, issues one request on the memory
// bus, waits for the response (with optional timeout) and reports the result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  mem_stage_if.master mem,
  output logic        busy,
  output logic        completed,
  output logic [31:0] result,
  output logic [1:0]  fault
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t      state_reg,      state_next;
  logic        req_valid_reg,  req_valid_next;
  logic        we_reg,         we_next;
  logic [31:0] addr_reg,       addr_next;
  logic [31:0] wdata_reg,      wdata_next;
  logic [3:0]  wstrb_reg,      wstrb_next;
  logic        completed_reg,  completed_next;
  logic [31:0] result_reg,     result_next;
  logic [1:0]  fault_reg,      fault_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic        is_load_reg,    is_load_next;
  logic [2:0]  funct3_reg,     funct3_next;
  logic [1:0]  addr_lo_reg,    addr_lo_next;

  logic [31:0] load_data;

  mem_stage_load_align u_load_align (
    .funct3  (funct3_reg),
    .addr_lo (addr_lo_reg),
    .rdata   (mem.mem_rdata),
    .data    (load_data)
  );

  always_comb begin
    state_next     = state_reg;
    req_valid_next = req_valid_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    completed_next = 1'b0;
    result_next    = result_reg;
    fault_next     = fault_reg;
    wait_cnt_next  = wait_cnt_reg;
    is_load_next   = is_load_reg;
    funct3_next    = funct3_reg;
    addr_lo_next   = addr_lo_reg;

    case (state_reg)
      ST_IDLE: begin
        if (enabled) begin
          if (!is_load && !is_store) begin
            result_next    = alu_result;
            fault_next     = FAULT_NONE;
            completed_next = 1'b1;
          end else if (!op_legal(is_load, is_store, funct3, alu_result[1:0])) begin
            result_next    = alu_result;
            fault_next     = FAULT_ILLEGAL;
            completed_next = 1'b1;
          end else begin
            state_next     = ST_REQ;
            req_valid_next = 1'b1;
            we_next        = is_store;
            addr_next      = {alu_result[31:2], 2'b00};
            wdata_next     = store_lanes(funct3[1:0], store_data);
            wstrb_next     = is_store ? store_strobe(funct3[1:0], alu_result[1:0]) : 4'b0000;
            is_load_next   = is_load;
            funct3_next    = funct3;
            addr_lo_next   = alu_result[1:0];
          end
        end
      end

      ST_REQ: begin
        if (mem.mem_req_ready) begin
          state_next     = ST_WAIT;
          req_valid_next = 1'b0;
          we_next        = 1'b0;
          wstrb_next     = 4'b0000;
          wait_cnt_next  = '0;
        end
      end

      ST_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (mem.mem_resp_valid) begin
          state_next     = ST_DONE;
          completed_next = 1'b1;
          fault_next     = FAULT_NONE;
          result_next    = is_load_reg ? load_data : 32'h0;
        end else if (TIMEOUT_EN && (wait_cnt_reg == CNT_LAST)) begin
          state_next     = ST_DONE;
          completed_next = 1'b1;
          fault_next     = FAULT_TIMEOUT;
          result_next    = 32'h0;
        end else begin
          wait_cnt_next  = wait_cnt_reg + CNT_W'(1);
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      req_valid_reg <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      wstrb_reg     <= 4'b0000;
      completed_reg <= 1'b0;
      result_reg    <= 32'h0;
      fault_reg     <= FAULT_NONE;
      wait_cnt_reg  <= '0;
      is_load_reg   <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_lo_reg   <= 2'b00;
    end else begin
      state_reg     <= state_next;
      req_valid_reg <= req_valid_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      completed_reg <= completed_next;
      result_reg    <= result_next;
      fault_reg     <= fault_next;
      wait_cnt_reg  <= wait_cnt_next;
      is_load_reg   <= is_load_next;
      funct3_reg    <= funct3_next;
      addr_lo_reg   <= addr_lo_next;
    end
  end

  assign mem.mem_req_valid = req_valid_reg;
  assign mem.mem_we        = we_reg;
  assign mem.mem_addr      = addr_reg;
  assign mem.mem_wdata     = wdata_reg;
  assign mem.mem_wstrb     = wstrb_reg;

  assign busy      = (state_reg != ST_IDLE);
  assign completed = completed_reg;
  assign result    = result_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage with a responder model and a result scoreboard,
// plus hand-written timeout/late-response and mid-transaction reset sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enabled = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy;
  logic        completed;
  logic [31:0] result;
  logic [1:0]  fault;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enabled    (enabled),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem        (bus),
    .busy       (busy),
    .completed  (completed),
    .result     (result),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          resp_dly;
    logic [31:0] exp_res;
    logic [1:0]  exp_fault;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  fault;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    exp_t        e;
    logic        done, any_req, req_seen, hs, stable;
    int          stall, wcyc;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_we;
    done = 1'b0; any_req = 1'b0; req_seen = 1'b0; hs = 1'b0; stable = 1'b1;
    stall = 0; wcyc = 0;
    c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0; c_we = 1'b0;
    e.res = v.exp_res; e.fault = v.exp_fault; e.lat = v.exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    enabled = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
    alu_result = v.alu; store_data = v.sdata;
    @(negedge clk);
    enabled = 1'b0; is_load = 1'b0; is_store = 1'b0;
    for (int i = 1; i <= 200 && !done; i++) begin
      if (i > 1) @(negedge clk);
      if (completed) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check($sformatf("op%0d result", idx), result, e.res);
        check($sformatf("op%0d fault", idx), 32'(fault), 32'(e.fault));
        check($sformatf("op%0d latency", idx), 32'(i), 32'(e.lat));
        check($sformatf("op%0d busy_at_done", idx), 32'(busy), 32'(v.exp_req));
        $display("op %0d: alu=0x%08h result=0x%08h fault=%0d latency=%0d", idx, v.alu, result, fault, i);
      end else if (bus.mem_req_valid) begin
        any_req = 1'b1;
        if (!req_seen) begin
          req_seen = 1'b1;
          c_addr = bus.mem_addr; c_wdata = bus.mem_wdata; c_wstrb = bus.mem_wstrb; c_we = bus.mem_we;
        end else if (bus.mem_addr !== c_addr || bus.mem_wdata !== c_wdata ||
                     bus.mem_wstrb !== c_wstrb || bus.mem_we !== c_we) begin
          stable = 1'b0;
        end
        bus.mem_req_ready = (stall >= v.rdy_dly);
        if (bus.mem_req_ready) hs = 1'b1;
        stall++;
      end else if (hs) begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_rdata      = v.rdata;
        bus.mem_resp_valid = (v.resp_dly >= 0) && (wcyc == v.resp_dly);
        wcyc++;
      end
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL op%0d watchdog: no completion within 200 cycles, expected latency %0d", idx, v.exp_lat);
      void'(sb_q.pop_front());
    end
    check($sformatf("op%0d req_issued", idx), 32'(any_req), 32'(v.exp_req));
    if (v.exp_req) begin
      check($sformatf("op%0d addr", idx), c_addr, v.exp_addr);
      check($sformatf("op%0d we", idx), 32'(c_we), 32'(v.exp_we));
      check($sformatf("op%0d wstrb", idx), 32'(c_wstrb), 32'(v.exp_wstrb));
      check($sformatf("op%0d stable", idx), 32'(stable), 32'd1);
    end
    if (v.exp_we) check($sformatf("op%0d wdata", idx), c_wdata, v.exp_wdata);
  endtask

  initial begin
    vec_t v;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;

    //        ld    st    f3      alu           sdata         rdata         rd rs  exp_res       flt   req   we    addr        wdata         wstrb    lat
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        0, -1, 32'h0000_1234, 2'd0, 1'b0, 1'b0, 32'h0,      32'h0,        4'b0000, 1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF11, 0, 0, 32'hFFFF_FF80, 2'd0, 1'b1, 1'b0, 32'h100,    32'h0,        4'b0000, 3};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 32'h0,       3, 0, 32'h0,         2'd0, 1'b1, 1'b1, 32'h100,    32'hBEEF_BEEF, 4'b1100, 6};
    vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, -1, 32'h0000_0101, 2'd1, 1'b0, 1'b0, 32'h0,      32'h0,        4'b0000, 1};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 0, 1, 32'h0000_8001, 2'd0, 1'b1, 1'b0, 32'h200,    32'h0,        4'b0000, 4};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0,        32'h1234_8001, 1, 2, 32'hFFFF_8001, 2'd0, 1'b1, 1'b0, 32'h200,    32'h0,        4'b0000, 6};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'h0,       0, 0, 32'h0,         2'd0, 1'b1, 1'b1, 32'h0,      32'hA5A5_A5A5, 4'b0010, 3};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,       0, 0, 32'h0,         2'd0, 1'b1, 1'b1, 32'h3FC,    32'hCAFE_F00D, 4'b1111, 3};
    vecs[8]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h1111_2222, 32'h0,       0, -1, 32'h0000_0040, 2'd1, 1'b0, 1'b0, 32'h0,      32'h0,        4'b0000, 1};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0048, 32'h0,        32'h0,        0, -1, 32'h0000_0048, 2'd1, 1'b0, 1'b0, 32'h0,      32'h0,        4'b0000, 1};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        0, -1, 32'h0000_0103, 2'd1, 1'b0, 1'b0, 32'h0,      32'h0,        4'b0000, 1};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1357_9BDF, 0, 3, 32'h1357_9BDF, 2'd0, 1'b1, 1'b0, 32'h10,     32'h0,        4'b0000, 6};
    vecs[12] = '{1'b1, 1'b0, 3'b100, 32'h0000_0002, 32'h0,        32'h00AB_0000, 0, 0, 32'h0000_00AB, 2'd0, 1'b1, 1'b0, 32'h0,      32'h0,        4'b0000, 3};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h0,        0, -1, 32'h0,         2'd2, 1'b1, 1'b0, 32'h20,     32'h0,        4'b0000, 6};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset completed", 32'(completed), 32'd0);
    check("reset result", result, 32'h0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset req_valid", 32'(bus.mem_req_valid), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) run_op(vecs[k], k);

    // Responses arriving after a timeout completion must not disturb anything.
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("late%0d completed", k), 32'(completed), 32'd0);
      check($sformatf("late%0d result", k), result, 32'h0);
      check($sformatf("late%0d fault", k), 32'(fault), 32'd2);
      check($sformatf("late%0d busy", k), 32'(busy), 32'd0);
    end
    bus.mem_resp_valid = 1'b0;

    // Leave a non-zero result behind, then reset in the middle of a WAIT.
    v = '{1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, -1, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1};
    run_op(v, 14);
    @(negedge clk);
    enabled = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h0;
    @(negedge clk);
    enabled = 1'b0; is_load = 1'b0;
    check("rstseq req_valid", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("rstseq busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstseq busy", 32'(busy), 32'd0);
    check("rstseq completed", 32'(completed), 32'd0);
    check("rstseq result", result, 32'h0);
    check("rstseq fault", 32'(fault), 32'd0);
    check("rstseq req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rstseq we", 32'(bus.mem_we), 32'd0);
    check("rstseq wstrb", 32'(bus.mem_wstrb), 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0055;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("stray completed", 32'(completed), 32'd0);
    check("stray busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("stray completed2", 32'(completed), 32'd0);
    check("stray result", result, 32'h0);

    v = '{1'b1, 1'b0, 3'b100, 32'h0000_0000, 32'h0, 32'h0000_00FF, 0, 0, 32'h0000_00FF, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 3};
    run_op(v, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "time limit");
  end

endmodule
